register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised successor to the single-write register file. Adds N read ports and M write ports with fixed write priority, optional write-to-read bypass, and an optional hardwired zero register. Also carries a per-register pending scoreboard for pipeline hazard checks and a serial dump engine (valid/ready) that replaces $display-based state printing. Sits in the decode/writeback boundary of the LemonPC core.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 1<<ADDR_WIDTH
DATA_WIDTH, 64, register width
NUM_RD, 2, read port count (1..4)
NUM_WR, 2, write port count (1..2); higher index has priority
BYPASS, 1, 1 = read data reflects same-cycle write data
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and allocs

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
rs  in  NUM_RD*ADDR_WIDTH  packed read addresses, port k at [k*AW +: AW]
rdata  out  NUM_RD*DATA_WIDTH  packed read data, combinational
rbusy  out  NUM_RD  pending bit of each read address
wen  in  NUM_WR  write enables
rd  in  NUM_WR*ADDR_WIDTH  packed write addresses
wdata  in  NUM_WR*DATA_WIDTH  packed write data
alloc_en  in  1  mark alloc_rd pending (issue of producer)
alloc_rd  in  ADDR_WIDTH  register to mark pending
dump_req  in  1  start a full-file dump
dump_valid  out  1  dump word valid
dump_ready  in  1  consumer accepts dump word
dump_idx  out  ADDR_WIDTH  index of current dump word
dump_data  out  DATA_WIDTH  value of current dump word
dump_done  out  1  one-cycle pulse after the last word handshakes

Behaviour:
- Reset (async assert, sync-deasserted externally): all registers 0, all pending bits 0, dump FSM IDLE; dump_valid=0, dump_idx=0, dump_done=0.
- Write: on posedge, wen[j] writes wdata[j] to rd[j]. Two ports hitting the same address: the higher j wins. ZERO_REG=1: writes to index 0 are dropped.
- Read: rdata[k] is combinational from rs[k]. ZERO_REG=1 and rs[k]==0 gives 0 regardless of bypass. BYPASS=1: if any wen[j] && rd[j]==rs[k] (and nonzero under ZERO_REG), return the highest-priority matching wdata; else the stored value. BYPASS=0: stored value only; the new value appears the cycle after the write.
- Scoreboard: each write clears pending[rd[j]] on posedge. alloc_en sets pending[alloc_rd]. Alloc and write to the same register in the same cycle: alloc wins, so the bit ends set. ZERO_REG=1: pending[0] is constant 0. rbusy[k]=pending[rs[k]] (registered state, no bypass).
- Dump FSM states:
  - IDLE: dump_req=1 moves to SEND with idx=0.
  - SEND: dump_valid=1; dump_data is the live value of register idx (stored value, no bypass). On dump_valid&&dump_ready: if idx==depth-1, go to DONE; else idx+1.
  - DONE: dump_done=1 for one cycle, then IDLE and idx=0.
- dump_req outside IDLE is ignored. While dump_ready=0, dump_idx and dump_valid hold; dump_data may change if the register under idx is written.
- Dump and writes run concurrently. A register written before its index is sent shows the new value.
- Reset mid-dump: immediate IDLE, valid=0, no done pulse.
- Address arithmetic wraps at depth. dump_idx does not increment past depth-1.

Decomposition:
- Shared package lemon_pkg holds the default ADDR_WIDTH/DATA_WIDTH constants, the reg_idx_t/xlen_t typedefs, and the dump FSM state enum (IDLE, SEND, DONE).
- One sub-module, rf_dump_fsm, contains the FSM, index counter and handshake, and takes the read value via a private read port.
- Storage, bypass and scoreboard stay in register_file_mp.

Test Plan:
- Reset then read all registers on both ports -> every rdata=0 and rbusy=0. Write x0=0xDEAD (ZERO_REG=1) -> x0 still reads 0.
- Same cycle: wen=2'b11, rd0=rd1=5, wdata0=0x11, wdata1=0x22 -> x5=0x22 next cycle. With BYPASS=1 and rs0=5 in that cycle -> rdata0=0x22. With BYPASS=0 -> rdata0 shows the old value until the next cycle.
- Scoreboard: alloc x7 -> rbusy=1 next cycle. Later write x7=0x33 -> rbusy=0 and rdata=0x33. Alloc and write x7 in one cycle -> rbusy stays 1.
- Dump with dump_ready always 1 after writing x1..x31=i*3 -> 32 words, idx 0..31, data 0,3,...,93; dump_done pulses one cycle after idx 31 handshakes.
- Dump with dump_ready toggling 1,0,0,1,... and a write of x4=0x99 while idx=2 stalled -> idx/valid held during stalls, word 4 reads 0x99, dump_req during SEND ignored.
- Assert rst_n=0 at idx=10 -> dump_valid=0 immediately, no dump_done. After release, a new dump_req starts again at idx 0 with all data 0.

Source files
------------

// File: rtl/lemon_pkg.sv
// Shared LemonPC core types: default register-file geometry, index/data types, dump FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lemon_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 64;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] xlen_t;

    // Serial dump engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/rf_dump_fsm.sv
// Serial register-file dump engine: walks indices 0..depth-1 over a valid/ready port.
// Latency: first word valid one cycle after dump_req; done pulses one cycle after the last handshake.
// Backpressure: dump_ready low holds dump_idx/dump_valid; dump_data tracks the live register value.
module rf_dump_fsm
    import lemon_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dump_req,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_idx,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_done,
    // private read port into the storage array
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_val
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    dump_state_t state;

    // Dump sequencing: registered valid/idx/done, one word per accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dump_done <= 1'b0;
                    if (dump_req) begin
                        state      <= SEND;
                        dump_valid <= 1'b1;
                        dump_idx   <= '0;
                    end
                end
                SEND: begin
                    // dump_req is deliberately not looked at here: a running dump is never restarted
                    if (dump_valid && dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_idx <= dump_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                    dump_idx  <= '0;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_idx   <= '0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

    // The word on offer is always the stored value under the current index.
    assign rd_addr   = dump_idx;
    assign dump_data = rd_val;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-priority, optional bypass, zero register, pending scoreboard and dump port.
// Latency: reads combinational; writes and scoreboard updates visible after the clock edge (same cycle with bypass).
// Backpressure: none on read/write ports; the dump port stalls on dump_ready without blocking writes.
module register_file_mp
    import lemon_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rs,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] rd,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_rd,
    input  logic                         dump_req,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [ADDR_WIDTH-1:0]        dump_idx,
    output logic [DATA_WIDTH-1:0]        dump_data,
    output logic                         dump_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pending;

    logic [ADDR_WIDTH-1:0] rs_a  [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_v  [NUM_RD];

    logic [ADDR_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0] dump_val;

    // True when the index names the hardwired zero register.
    function automatic logic is_zero_idx(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Storage writes: ports are applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wen[j] && !is_zero_idx(rd[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    mem[rd[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Pending scoreboard: writebacks clear, issue sets; set is applied last so alloc beats a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wen[j]) begin
                    pending[rd[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                end
            end
            if (alloc_en) begin
                pending[alloc_rd] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                pending[0] <= 1'b0;
            end
        end
    end

    // Read ports: stored value, optionally overridden by the highest-priority same-cycle write.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rs_a[k] = rs[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_v[k] = mem[rs_a[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wen[j] && (rd[j*ADDR_WIDTH +: ADDR_WIDTH] == rs_a[k])) begin
                        rd_v[k] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            // the zero register overrides any bypass match
            if (is_zero_idx(rs_a[k])) begin
                rd_v[k] = '0;
            end
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_v[k];
            // busy reflects registered state only, never the same-cycle write
            rbusy[k] = pending[rs_a[k]];
        end
    end

    // Private dump read port: stored value only, no bypass.
    always_comb begin
        dump_val = mem[dump_addr];
        if (is_zero_idx(dump_addr)) begin
            dump_val = '0;
        end
    end

    rf_dump_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .rd_addr    (dump_addr),
        .rd_val     (dump_val)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: vector table for ports/scoreboard, queue scoreboard for dumps.
// Latency: n/a.
// Backpressure: exercised via a toggling dump_ready pattern.
module tb_register_file_mp;
    import lemon_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*AW-1:0]   rs;
    logic [2*DW-1:0]   rdata, rdata_nb;
    logic [1:0]        rbusy, rbusy_nb;
    logic [1:0]        wen;
    logic [2*AW-1:0]   rd;
    logic [2*DW-1:0]   wdata;
    logic              alloc_en;
    logic [AW-1:0]     alloc_rd;
    logic              dump_req, dump_ready;
    logic              dump_valid, dump_done, dump_valid_nb, dump_done_nb;
    logic [AW-1:0]     dump_idx, dump_idx_nb;
    logic [DW-1:0]     dump_data, dump_data_nb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .rd(rd), .wdata(wdata), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
    );

    register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen(wen), .rd(rd), .wdata(wdata), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .dump_req(dump_req), .dump_valid(dump_valid_nb), .dump_ready(dump_ready),
        .dump_idx(dump_idx_nb), .dump_data(dump_data_nb), .dump_done(dump_done_nb)
    );

    typedef struct packed {
        logic [1:0] wen;
        reg_idx_t   rd0;
        reg_idx_t   rd1;
        xlen_t      wd0;
        xlen_t      wd1;
        logic       alloc;
        reg_idx_t   ard;
        reg_idx_t   rs0;
        reg_idx_t   rs1;
        xlen_t      e0;
        xlen_t      e1;
        xlen_t      enb;
        logic [1:0] ebusy;
    } vec_t;

    typedef struct packed {
        reg_idx_t idx;
        xlen_t    data;
    } dump_exp_t;

    localparam int NVEC = 16;
    vec_t      vecs [NVEC];
    dump_exp_t sb [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one dump; mode 1 toggles ready 1,0,0, writes x4 while idx 2 stalls, and pulses dump_req mid-dump.
    task automatic run_dump(input int mode, input string tag);
        int        cyc, last_hs, ndone;
        logic      fin, wrote, prev_stall;
        reg_idx_t  prev_idx;
        dump_exp_t e;
        cyc = 0; last_hs = -10; ndone = 0; fin = 1'b0; wrote = 1'b0; prev_stall = 1'b0; prev_idx = '0;
        @(negedge clk);
        dump_req = 1'b1; dump_ready = 1'b1;
        @(posedge clk);
        while (!fin && cyc < 400) begin
            @(negedge clk);
            dump_req = (mode == 1 && cyc == 5);
            wen = '0;
            if (mode == 1) begin
                dump_ready = (cyc % 3 == 0);
                if (!wrote && dump_idx == 5'd2 && !dump_ready) begin
                    wen = 2'b01; rd = {5'd0, 5'd4}; wdata = {64'd0, 64'h99}; wrote = 1'b1;
                end
            end else begin
                dump_ready = 1'b1;
            end
            #1;
            if (prev_stall) begin
                check($sformatf("%s_hold_idx", tag), dump_idx, prev_idx);
                check($sformatf("%s_hold_valid", tag), dump_valid, 1'b1);
            end
            if (dump_valid && dump_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s_extra_word: got idx %0d expected no word", tag, dump_idx);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s_idx", tag), dump_idx, e.idx);
                    check($sformatf("%s_data_%0d", tag, e.idx), dump_data, e.data);
                end
                if (dump_idx == 5'd31) last_hs = cyc;
            end
            if (dump_done) begin
                ndone++;
                check($sformatf("%s_done_timing", tag), cyc, last_hs + 1);
                fin = 1'b1;
            end
            prev_stall = dump_valid && !dump_ready;
            prev_idx   = dump_idx;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        wen = '0; dump_req = 1'b0;
        #1;
        check($sformatf("%s_finished", tag), fin, 1'b1);
        check($sformatf("%s_sb_empty", tag), sb.size(), 0);
        check($sformatf("%s_done_count", tag), ndone, 1);
        check($sformatf("%s_done_single", tag), dump_done, 1'b0);
        check($sformatf("%s_idle_valid", tag), dump_valid, 1'b0);
        check($sformatf("%s_idle_idx", tag), dump_idx, 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dump_exp_t e;
        //          wen    rd0   rd1   wd0          wd1         al    ard   rs0   rs1   e0          e1          enb         busy
        vecs[0]  = '{2'b01, 5'd0, 5'd0, 64'hDEAD,    64'h0,      1'b0, 5'd0, 5'd0, 5'd0, 64'h0,      64'h0,      64'h0,      2'b00};
        vecs[1]  = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd0, 5'd5, 64'h0,      64'h0,      64'h0,      2'b00};
        vecs[2]  = '{2'b11, 5'd5, 5'd5, 64'h11,      64'h22,     1'b0, 5'd0, 5'd5, 5'd5, 64'h22,     64'h22,     64'h0,      2'b00};
        vecs[3]  = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd5, 5'd5, 64'h22,     64'h22,     64'h22,     2'b00};
        vecs[4]  = '{2'b11, 5'd5, 5'd6, 64'h44,      64'h55,     1'b0, 5'd0, 5'd5, 5'd6, 64'h44,     64'h55,     64'h22,     2'b00};
        vecs[5]  = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd5, 5'd6, 64'h44,     64'h55,     64'h44,     2'b00};
        vecs[6]  = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b1, 5'd7, 5'd7, 5'd5, 64'h0,      64'h44,     64'h0,      2'b00};
        vecs[7]  = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd7, 5'd7, 64'h0,      64'h0,      64'h0,      2'b11};
        vecs[8]  = '{2'b01, 5'd7, 5'd0, 64'h33,      64'h0,      1'b0, 5'd0, 5'd7, 5'd3, 64'h33,     64'h0,      64'h0,      2'b01};
        vecs[9]  = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd7, 5'd7, 64'h33,     64'h33,     64'h33,     2'b00};
        vecs[10] = '{2'b10, 5'd0, 5'd7, 64'h0,       64'h77,     1'b1, 5'd7, 5'd7, 5'd7, 64'h77,     64'h77,     64'h33,     2'b00};
        vecs[11] = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd7, 5'd7, 64'h77,     64'h77,     64'h77,     2'b11};
        vecs[12] = '{2'b11, 5'd0, 5'd9, 64'h1,       64'h99,     1'b1, 5'd0, 5'd0, 5'd9, 64'h0,      64'h99,     64'h0,      2'b00};
        vecs[13] = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd0, 5'd9, 64'h0,      64'h99,     64'h0,      2'b00};
        vecs[14] = '{2'b10, 5'd0, 5'd7, 64'h0,       64'h78,     1'b0, 5'd0, 5'd7, 5'd9, 64'h78,     64'h99,     64'h77,     2'b01};
        vecs[15] = '{2'b00, 5'd0, 5'd0, 64'h0,       64'h0,      1'b0, 5'd0, 5'd7, 5'd7, 64'h78,     64'h78,     64'h78,     2'b00};

        rs = '0; wen = '0; rd = '0; wdata = '0; alloc_en = 1'b0; alloc_rd = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dump_valid", dump_valid, 1'b0);
        check("rst_dump_idx", dump_idx, 0);
        check("rst_dump_done", dump_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // every register reads zero and idle on both ports after reset
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            rs = {5'(DEPTH - 1 - a), 5'(a)};
            #1;
            check($sformatf("rst_rdata_%0d", a), rdata, 128'd0);
            check($sformatf("rst_rbusy_%0d", a), rbusy, 2'b00);
        end

        // table-driven port/scoreboard vectors, outputs sampled before each row commits
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wen      = vecs[i].wen;
            rd       = {vecs[i].rd1, vecs[i].rd0};
            wdata    = {vecs[i].wd1, vecs[i].wd0};
            alloc_en = vecs[i].alloc;
            alloc_rd = vecs[i].ard;
            rs       = {vecs[i].rs1, vecs[i].rs0};
            #1;
            check($sformatf("v%0d_rdata0", i), rdata[DW-1:0], vecs[i].e0);
            check($sformatf("v%0d_rdata1", i), rdata[2*DW-1:DW], vecs[i].e1);
            check($sformatf("v%0d_nobypass_rdata0", i), rdata_nb[DW-1:0], vecs[i].enb);
            check($sformatf("v%0d_rbusy", i), rbusy, vecs[i].ebusy);
        end
        @(negedge clk);
        wen = '0; alloc_en = 1'b0;

        // fill x1..x31 with i*3
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            wen = 2'b01; rd = {5'd0, 5'(i)}; wdata = {64'd0, 64'(i * 3)};
        end
        @(negedge clk);
        wen = '0;

        // full dump with ready held high
        for (int i = 0; i < DEPTH; i++) begin
            e.idx = 5'(i); e.data = 64'(i * 3);
            sb.push_back(e);
        end
        run_dump(0, "dump_full");

        // stalled dump, x4 rewritten before it is sent
        for (int i = 0; i < DEPTH; i++) begin
            e.idx = 5'(i); e.data = (i == 4) ? 64'h99 : 64'(i * 3);
            sb.push_back(e);
        end
        run_dump(1, "dump_stall");

        // reset in the middle of a dump
        @(negedge clk);
        dump_req = 1'b1; dump_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dump_req = 1'b0;
        n = 0;
        while (dump_idx != 5'd10 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("mid_idx_reached", dump_idx, 10);
        rst_n = 1'b0;
        rs = {5'd9, 5'd5};
        #1;
        check("mid_rst_valid", dump_valid, 1'b0);
        check("mid_rst_done", dump_done, 1'b0);
        check("mid_rst_idx", dump_idx, 0);
        check("mid_rst_rdata", rdata, 128'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("mid_rst_no_done_%0d", c), dump_done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // fresh dump after reset sees an all-zero file
        for (int i = 0; i < DEPTH; i++) begin
            e.idx = 5'(i); e.data = 64'd0;
            sb.push_back(e);
        end
        run_dump(0, "dump_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
